// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU front end: ALU control codes and the
// arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_RESP = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational 64-bit ALU: AND/ORR/ADD/SUB/PASSB/NOR, any other code yields 0.
// Arithmetic wraps modulo 2^WIDTH; carry and overflow are not produced.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  // ALU function decode
  always_comb begin
    result_o = {WIDTH{1'b0}};
    case (op_i)
      ALU_AND:   result_o = a_i & b_i;
      ALU_ORR:   result_o = a_i | b_i;
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_PASSB: result_o = b_i;
      ALU_NOR:   result_o = ~(a_i | b_i);
      default:   result_o = {WIDTH{1'b0}};
    endcase
    zero_o = (result_o == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester front end sharing one alu_core, with a registered valid/ready result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [WIDTH-1:0] req_imm0,
  input  logic [WIDTH-1:0] req_imm1,
  input  logic [1:0]       req_src,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  arb_state_t       state_q, state_d;
  logic             grant_s;
  logic             accept_s;
  logic [WIDTH-1:0] opa_s, opb_s;
  logic [OPW-1:0]   op_s;
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_zero_s;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             id_q, id_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 only wins when requester 0 is idle
  always_comb begin
    grant_s = ~req_valid[0];
  end
`else
  logic last_q, last_d;

  // Round-robin: on contention the requester that was not granted last wins
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_s = ~last_q;
    end else begin
      grant_s = req_valid[1];
    end
  end

  // Grant pointer moves only on an accepted transfer
  always_comb begin
    if (accept_s) begin
      last_d = grant_s;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Accept depends only on state, req_valid and pointer; rst_n masks ready during reset
  always_comb begin
    accept_s = rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00);
    if (accept_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Grant-selected operand mux with per-requester ALUSrc
  always_comb begin
    if (grant_s) begin
      opa_s = req_a1;
      opb_s = req_src[1] ? req_imm1 : req_b1;
      op_s  = req_op1;
    end else begin
      opa_s = req_a0;
      opb_s = req_src[0] ? req_imm0 : req_b0;
      op_s  = req_op0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .a_i      (opa_s),
    .b_i      (opb_s),
    .op_i     (op_s),
    .result_o (alu_result_s),
    .zero_o   (alu_zero_s)
  );

  // FSM next state and result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    id_d     = id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_RESP;
          result_d = alu_result_s;
          zero_d   = alu_zero_s;
          id_d     = grant_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; async reset discards any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the driver pushes hand-computed expectations
// on each accept, a negedge monitor pops and compares on every rsp handshake.
module tb_alu_share_arbiter;

  localparam int WIDTH = 64;
  localparam int OPW   = 4;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] result;
    logic             zero;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1, req_imm0, req_imm1;
  logic [1:0]       req_src;
  logic [OPW-1:0]   req_op0, req_op1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .req_imm0   (req_imm0),
    .req_imm1   (req_imm1),
    .req_src    (req_src),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every handshaken response against the scoreboard
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
        check("rsp_result", rsp_result, e.result);
        check("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
      end
    end
    if (req_ready == 2'b11) check("ready_onehot", 64'd1, 64'd0);
  end

  task automatic push_exp(input logic id, input logic [WIDTH-1:0] res);
    exp_t e;
    e.id = id;
    e.result = res;
    e.zero = (res == 64'd0);
    sb_q.push_back(e);
  endtask

  // Drive one request (caller is just after a posedge) and wait, bounded, for its accept
  task automatic issue(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] imm, input logic s, input logic [3:0] op,
                       input logic [WIDTH-1:0] exp_res);
    bit found;
    if (r == 0) begin
      req_a0 = a; req_b0 = b; req_imm0 = imm; req_op0 = op; req_src[0] = s;
    end else begin
      req_a1 = a; req_b1 = b; req_imm1 = imm; req_op1 = op; req_src[1] = s;
    end
    req_valid[r] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        found = 1'b1;
        push_exp(r[0], exp_res);
      end
    end
    if (!found) check("issue_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] exp_grants[4];
  int         g;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b11; req_src = 2'b00;
    req_a0 = 64'd0; req_b0 = 64'd0; req_imm0 = 64'd0; req_op0 = 4'b0000;
    req_a1 = 64'd0; req_b1 = 64'd0; req_imm1 = 64'd0; req_op1 = 4'b0000;

    // Reset with both requesters valid
    @(negedge clk);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_zero", {63'd0, rsp_zero}, 64'd0);
    check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_ready", {62'd0, req_ready}, 64'd1);
    push_exp(1'b0, 64'd0);   // req0: 0 AND 0
    @(posedge clk); #1 req_valid = 2'b00;

    // Directed single requests
    issue(0, 64'd5, 64'd3, 64'd0, 1'b0, 4'b0110, 64'd2);
    issue(1, 64'h100, 64'hFFFF, 64'h8, 1'b1, 4'b0010, 64'h108);
    issue(0, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, 4'b0000, 64'h00F0);
    issue(1, 64'hF000, 64'h000F, 64'd0, 1'b0, 4'b0001, 64'hF00F);
    issue(0, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 64'd0, 1'b0, 4'b1100, 64'h0000_0000_0000_00FF);
    issue(1, 64'h1234, 64'h55, 64'hABCD, 1'b1, 4'b0111, 64'hABCD);
    issue(0, 64'h1234, 64'h55, 64'd0, 1'b0, 4'b0011, 64'd0);
    issue(0, 64'd3, 64'd5, 64'd0, 1'b0, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE);
    drain();

    // Contention with rsp_ready held high
    do_reset();
    req_a0 = 64'd10; req_b0 = 64'd4; req_op0 = 4'b0010; req_src = 2'b00;
    req_a1 = 64'd10; req_b1 = 64'd4; req_op1 = 4'b0110;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req_valid = 2'b11;
    g = 0;
    for (int i = 0; i < 30 && g < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("contention_grant", {62'd0, req_ready}, {62'd0, exp_grants[g]});
        if (exp_grants[g] == 2'b01) push_exp(1'b0, 64'd14);
        else push_exp(1'b1, 64'd6);
        g++;
      end
    end
    if (g != 4) check("contention_timeout", 64'(g), 64'd4);
    @(posedge clk); #1 req_valid = 2'b00;
    drain();

    // Backpressure with wrap-around add, req1 waiting
    rsp_ready = 1'b0;
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 4'b0010, 64'd0);
    req_a1 = 64'hF0; req_b1 = 64'hFF; req_op1 = 4'b0000; req_src[1] = 1'b0;
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rsp_result", rsp_result, 64'd0);
      check("bp_rsp_zero", {63'd0, rsp_zero}, 64'd1);
      check("bp_req_ready", {62'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_idle_ready", {62'd0, req_ready}, 64'd2);
    if (req_ready == 2'b10) push_exp(1'b1, 64'hF0);
    @(posedge clk); #1 req_valid = 2'b00;
    drain();

    // Reset while a response is pending
    rsp_ready = 1'b0;
    issue(0, 64'd7, 64'd9, 64'd0, 1'b0, 4'b0010, 64'd16);
    @(negedge clk);
    check("mid_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_drop_valid", {63'd0, rsp_valid}, 64'd0);
    check("async_clear_result", rsp_result, 64'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
